// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Purpose : Shares one byte-wide RAM/IO port between icache refill (IC) and
//           the load/store buffer (LS); optional macro ARB_RR_EN selects
//           round-robin instead of fixed LS-over-IC priority.
// Rev     : 1.0
// ============================================================================
module mem_arbiter #(
  parameter int          LINE_BYTES = 16,
  parameter logic [31:0] IO_BASE    = 32'h30000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    clear,
  input  logic                    ic_req,
  input  logic [31:0]             ic_addr,
  output logic                    ic_done,
  output logic [LINE_BYTES*8-1:0] ic_line,
  input  logic                    ls_req,
  input  logic                    ls_wr,
  input  logic [1:0]              ls_size,
  input  logic [31:0]             ls_addr,
  input  logic [31:0]             ls_wdata,
  output logic                    ls_done,
  output logic [31:0]             ls_rdata,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [31:0]             mem_a,
  output logic                    mem_wr,
  input  logic                    io_buffer_full
);

  localparam int              CW          = $clog2(LINE_BYTES) + 1;
  localparam logic [CW-1:0]   c_line_n    = CW'(LINE_BYTES);
  localparam logic [31:0]     c_line_mask = ~(32'(LINE_BYTES) - 32'd1);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_ic_rd = 3'd1;
  localparam logic [2:0] c_st_ls_rd = 3'd2;
  localparam logic [2:0] c_st_ls_wr = 3'd3;
  localparam logic [2:0] c_st_done  = 3'd4;

  logic [2:0]    r_state, w_state_nx;
  logic [31:0]   r_base;
  logic [31:0]   r_wdata;
  logic [CW-1:0] r_n;
  logic [CW-1:0] r_cnt;     // bytes already sampled / written
  logic [CW-1:0] r_aidx;    // byte index currently on mem_a (reads)
  logic          r_alive;   // mem_a holds a live read address this cycle
  logic          r_pv;      // mem_din carries byte r_cnt this cycle
  logic          r_is_ic;
  logic          r_is_st;
  logic          r_last_ls;

  logic          w_ic_ok, w_ls_ok, w_grant_ic, w_grant_ls;
  logic          w_last, w_io_blk;
  logic [31:0]   w_waddr, w_aaddr_nx;
  logic [7:0]    w_wbyte;
  logic [CW-1:0] w_ls_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= c_st_idle;
    else      r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    if (rdy) begin
      case (r_state)
        c_st_idle: begin
          if (w_grant_ls)      w_state_nx = ls_wr ? c_st_ls_wr : c_st_ls_rd;
          else if (w_grant_ic) w_state_nx = c_st_ic_rd;
        end
        c_st_ic_rd, c_st_ls_rd: begin
          if (clear)               w_state_nx = c_st_idle;
          else if (r_pv && w_last) w_state_nx = c_st_done;
        end
        c_st_ls_wr: if (!w_io_blk && w_last) w_state_nx = c_st_done;
        default:    w_state_nx = c_st_idle;
      endcase
    end
  end

  always_comb begin
    w_ic_ok = ic_req && !clear;
    w_ls_ok = ls_req && (ls_wr || !clear);  // committed stores ignore clear
`ifdef ARB_RR_EN
    w_grant_ls = w_ls_ok && (!w_ic_ok || !r_last_ls);
`else
    w_grant_ls = w_ls_ok;
`endif
    w_grant_ic = w_ic_ok && !w_grant_ls;
    case (ls_size)
      2'd0:    w_ls_n = CW'(1);
      2'd1:    w_ls_n = CW'(2);
      default: w_ls_n = CW'(4);
    endcase
    w_last     = (r_cnt == r_n - CW'(1));
    w_waddr    = r_base + 32'(r_cnt);
    w_aaddr_nx = r_base + 32'(r_aidx + CW'(1));
    w_io_blk   = (w_waddr >= IO_BASE) && io_buffer_full;
    case (r_cnt[1:0])
      2'd0:    w_wbyte = r_wdata[7:0];
      2'd1:    w_wbyte = r_wdata[15:8];
      2'd2:    w_wbyte = r_wdata[23:16];
      default: w_wbyte = r_wdata[31:24];
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_a     <= '0;
      mem_dout  <= '0;
      mem_wr    <= 1'b0;
      ic_done   <= 1'b0;
      ls_done   <= 1'b0;
      ic_line   <= '0;
      ls_rdata  <= '0;
      r_base    <= '0;
      r_wdata   <= '0;
      r_n       <= '0;
      r_cnt     <= '0;
      r_aidx    <= '0;
      r_alive   <= 1'b0;
      r_pv      <= 1'b0;
      r_is_ic   <= 1'b0;
      r_is_st   <= 1'b0;
      r_last_ls <= 1'b0;
    end else begin
      ic_done <= 1'b0;
      ls_done <= 1'b0;
      mem_wr  <= 1'b0;
      if (!rdy) begin
        // The in-flight byte is lost while frozen; rewind to the first unsampled one.
        if (r_state == c_st_ic_rd || r_state == c_st_ls_rd) begin
          r_pv    <= 1'b0;
          r_alive <= 1'b1;
          r_aidx  <= r_cnt;
          mem_a   <= w_waddr;
        end
      end else begin
        case (r_state)
          c_st_idle: begin
            if (w_grant_ls || w_grant_ic) begin
              r_base    <= w_grant_ls ? ls_addr : (ic_addr & c_line_mask);
              mem_a     <= w_grant_ls ? ls_addr : (ic_addr & c_line_mask);
              r_n       <= w_grant_ls ? w_ls_n : c_line_n;
              r_is_ic   <= w_grant_ic;
              r_is_st   <= w_grant_ls && ls_wr;
              r_last_ls <= w_grant_ls;
              r_wdata   <= ls_wdata;
              r_cnt     <= '0;
              r_aidx    <= '0;
              r_alive   <= !(w_grant_ls && ls_wr);
              r_pv      <= 1'b0;
              if (w_grant_ls && !ls_wr) ls_rdata <= '0;
            end
          end
          c_st_ic_rd, c_st_ls_rd: begin
            if (clear) begin
              r_alive <= 1'b0;
              r_pv    <= 1'b0;
            end else begin
              if (r_pv) begin
                if (r_is_ic) begin
                  for (int i = 0; i < LINE_BYTES; i++)
                    if (r_cnt == CW'(i)) ic_line[i*8 +: 8] <= mem_din;
                end else begin
                  case (r_cnt[1:0])
                    2'd0:    ls_rdata[7:0]   <= mem_din;
                    2'd1:    ls_rdata[15:8]  <= mem_din;
                    2'd2:    ls_rdata[23:16] <= mem_din;
                    default: ls_rdata[31:24] <= mem_din;
                  endcase
                end
                r_cnt <= r_cnt + CW'(1);
              end
              r_pv <= r_alive;
              if (r_alive) begin
                if (r_aidx == r_n - CW'(1)) begin
                  r_alive <= 1'b0;
                end else begin
                  r_aidx <= r_aidx + CW'(1);
                  mem_a  <= w_aaddr_nx;
                end
              end
            end
          end
          c_st_ls_wr: begin
            if (!w_io_blk) begin
              mem_a    <= w_waddr;
              mem_dout <= w_wbyte;
              mem_wr   <= 1'b1;
              r_cnt    <= r_cnt + CW'(1);
            end
          end
          c_st_done: begin
            if (r_is_st || !clear) begin
              ic_done <= r_is_ic;
              ls_done <= !r_is_ic;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Purpose : Scoreboard bench for mem_arbiter: directed transfers, expected
//           writes/done pulses queued at issue and checked by a monitor.
// Rev     : 1.0
// ============================================================================
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst, rdy, clear;
  logic         ic_req;
  logic [31:0]  ic_addr;
  logic         ic_done;
  logic [127:0] ic_line;
  logic         ls_req, ls_wr;
  logic [1:0]   ls_size;
  logic [31:0]  ls_addr, ls_wdata, ls_rdata;
  logic         ls_done;
  logic [7:0]   mem_din = 8'h00;
  logic [7:0]   mem_dout;
  logic [31:0]  mem_a;
  logic         mem_wr;
  logic         io_buffer_full;

  mem_arbiter #(.LINE_BYTES(16), .IO_BASE(32'h30000)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_line(ic_line),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: byte at address A reads back as A[7:0], one cycle later.
  always @(posedge clk) mem_din <= mem_a[7:0];

  typedef struct { logic [31:0] a; logic [7:0] d; } wr_exp_t;
  typedef struct { logic [127:0] line; int cyc; } ic_exp_t;
  typedef struct { logic chk; logic [31:0] d; } ls_exp_t;

  wr_exp_t    wr_q[$];
  ic_exp_t    ic_q[$];
  ls_exp_t    ls_q[$];
  logic [1:0] ord_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got none/unexpected event expected opposite", nm);
  endtask

  wr_exp_t    m_w;
  ic_exp_t    m_i;
  ls_exp_t    m_l;

  always @(negedge clk) begin
    if (rst) begin
      if (mem_wr) begin
        if (wr_q.size() == 0) miss("unexpected_write");
        else begin
          m_w = wr_q.pop_front();
          chk("wr_addr", 128'(mem_a), 128'(m_w.a));
          chk("wr_data", 128'(mem_dout), 128'(m_w.d));
        end
      end
      if (ic_done || ls_done) begin
        if (ord_q.size() == 0) miss("unexpected_done");
        else chk("done_port", 128'({ic_done, ls_done}), 128'(ord_q.pop_front()));
      end
      if (ic_done) begin
        if (ic_q.size() == 0) miss("unexpected_ic_done");
        else begin
          m_i = ic_q.pop_front();
          chk("ic_line", ic_line, m_i.line);
          if (m_i.cyc != 0) chk("ic_latency", 128'(cyc), 128'(m_i.cyc));
        end
      end
      if (ls_done) begin
        if (ls_q.size() == 0) miss("unexpected_ls_done");
        else begin
          m_l = ls_q.pop_front();
          if (m_l.chk) chk("ls_rdata", 128'(ls_rdata), 128'(m_l.d));
        end
      end
    end
  end

  task automatic wait_pulse(input bit is_ic);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (is_ic ? ic_done : ls_done) return;
    end
    miss(is_ic ? "ic_done_timeout" : "ls_done_timeout");
  endtask

  task automatic do_ic(input logic [31:0] a, input bit lat);
    ic_exp_t     e;
    logic [31:0] b;
    @(negedge clk);
    b = a & 32'hFFFF_FFF0;
    for (int i = 0; i < 16; i++) e.line[i*8 +: 8] = 8'(b + 32'(i));
    e.cyc = lat ? cyc + 19 : 0;
    ic_q.push_back(e);
    ic_addr = a;
    ic_req  = 1'b1;
    wait_pulse(1'b1);
    ic_req  = 1'b0;
  endtask

  task automatic do_ls(input bit wr, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp);
    ls_exp_t e;
    wr_exp_t w;
    int      nb;
    @(negedge clk);
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (wr) begin
      for (int k = 0; k < nb; k++) begin
        w.a = a + 32'(k);
        w.d = wd[k*8 +: 8];
        wr_q.push_back(w);
      end
    end
    e.chk = !wr;
    e.d   = exp;
    ls_q.push_back(e);
    ls_wr = wr; ls_size = sz; ls_addr = a; ls_wdata = wd; ls_req = 1'b1;
    wait_pulse(1'b0);
    ls_req = 1'b0;
  endtask

  task automatic wait_write_at(input logic [31:0] a);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (mem_wr && mem_a == a) return;
    end
    miss("write_wait_timeout");
  endtask

  task automatic wait_addr(input logic [31:0] a);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (mem_a == a) return;
    end
    miss("addr_wait_timeout");
  endtask

  logic [31:0] held_a;
  wr_exp_t     rw;

  initial begin
    rst = 1'b0; rdy = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
    ic_req = 1'b0; ic_addr = '0; ls_req = 1'b0; ls_wr = 1'b0;
    ls_size = '0; ls_addr = '0; ls_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_mem_a", 128'(mem_a), 128'(0));
    chk("rst_mem_wr", 128'(mem_wr), 128'(0));
    chk("rst_ic_done", 128'(ic_done), 128'(0));
    chk("rst_ls_done", 128'(ls_done), 128'(0));
    chk("rst_ic_line", ic_line, 128'(0));
    rst = 1'b1;

    // Line refill with latency check, then loads incl. size 3 and address wrap.
    ord_q.push_back(2'b10); do_ic(32'h1000, 1'b1);
    ord_q.push_back(2'b01); do_ls(1'b0, 2'd1, 32'h2003, '0, 32'h0000_0403);
    ord_q.push_back(2'b01); do_ls(1'b0, 2'd0, 32'h20FF, '0, 32'h0000_00FF);
    ord_q.push_back(2'b01); do_ls(1'b0, 2'd3, 32'h2010, '0, 32'h1312_1110);
    ord_q.push_back(2'b01); do_ls(1'b0, 2'd2, 32'hFFFF_FFFE, '0, 32'h0100_FFFE);

    // IO store with the sink full for 3 cycles at byte 1.
    ord_q.push_back(2'b01);
    fork
      do_ls(1'b1, 2'd2, 32'h30000, 32'hDEAD_BEEF, '0);
      begin
        wait_write_at(32'h30000);
        io_buffer_full = 1'b1;
        repeat (3) @(negedge clk);
        io_buffer_full = 1'b0;
      end
    join

    // Simultaneous requests; last grant was LS.
`ifdef ARB_RR_EN
    ord_q.push_back(2'b10); ord_q.push_back(2'b01);
`else
    ord_q.push_back(2'b01); ord_q.push_back(2'b10);
`endif
    fork
      do_ic(32'h1200, 1'b0);
      do_ls(1'b0, 2'd1, 32'h2003, '0, 32'h0000_0403);
    join

    // Clear while byte 7 of a refill is addressed: no done, address frozen.
    @(negedge clk);
    ic_addr = 32'h1100; ic_req = 1'b1;
    wait_addr(32'h1107);
    clear = 1'b1; ic_req = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    held_a = mem_a;
    chk("clear_ic_addr", 128'(held_a), 128'(32'h1107));
    repeat (3) @(negedge clk);
    chk("clear_ic_stop", 128'(mem_a), 128'(held_a));
    repeat (25) @(negedge clk);

    // Clear during a committed store: all bytes still go out.
    ord_q.push_back(2'b01);
    fork
      do_ls(1'b1, 2'd2, 32'h500, 32'h1122_3344, '0);
      begin
        wait_write_at(32'h500);
        clear = 1'b1;
        repeat (2) @(negedge clk);
        clear = 1'b0;
      end
    join

    // rdy low for 5 cycles in the middle of a refill.
    ord_q.push_back(2'b10);
    fork
      do_ic(32'h1040, 1'b0);
      begin
        wait_addr(32'h1045);
        rdy = 1'b0;
        repeat (5) @(negedge clk);
        rdy = 1'b1;
      end
    join

    // Asynchronous reset in the middle of a store.
    @(negedge clk);
    rw.a = 32'h400; rw.d = 8'h02; wr_q.push_back(rw);
    ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h400; ls_wdata = 32'hA5A5_0102; ls_req = 1'b1;
    wait_write_at(32'h400);
    #1 rst = 1'b0; ls_req = 1'b0;
    #1;
    chk("arst_mem_a", 128'(mem_a), 128'(0));
    chk("arst_mem_wr", 128'(mem_wr), 128'(0));
    chk("arst_mem_dout", 128'(mem_dout), 128'(0));
    chk("arst_ic_line", ic_line, 128'(0));
    chk("arst_ls_rdata", 128'(ls_rdata), 128'(0));
    @(negedge clk);
    rst = 1'b1;

    // Low address bits of the refill address are ignored.
    ord_q.push_back(2'b10); do_ic(32'h1005, 1'b1);

    repeat (10) @(negedge clk);
    chk("wr_q_empty", 128'(wr_q.size()), 128'(0));
    chk("ic_q_empty", 128'(ic_q.size()), 128'(0));
    chk("ls_q_empty", 128'(ls_q.size()), 128'(0));
    chk("ord_q_empty", 128'(ord_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
